// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   state_t   : sequencer FSM states
//   LOST_W    : width of the lock-loss event counter
//   cnt_width : width of a counter that must reach the largest of three limits
package pll_reset_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_STABLE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int LOST_W = 8;

  // One spare bit above $clog2 so that a limit that is an exact power of two
  // still fits without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Status/control bundle between the PLL reset sequencer and its system.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
//   locked       : raw PLL lock, asynchronous to clk
//   lost_clr     : one-cycle pulse clearing lost_count
//   sys_rst_n    : core reset, active-low, released first
//   periph_rst_n : peripheral reset, active-low, released later
//   ready        : mirrors periph_rst_n
//   lost_count   : saturating lock-loss counter
//   timeout_err  : sticky lock-timeout flag
interface pll_reset_seq_if;
  import pll_reset_pkg::*;

  logic              locked;
  logic              lost_clr;
  logic              sys_rst_n;
  logic              periph_rst_n;
  logic              ready;
  logic [LOST_W-1:0] lost_count;
  logic              timeout_err;

  // Sequencer side
  modport slave (
    input  locked,
    input  lost_clr,
    output sys_rst_n,
    output periph_rst_n,
    output ready,
    output lost_count,
    output timeout_err
  );

  // System side
  modport master (
    output locked,
    output lost_clr,
    input  sys_rst_n,
    input  periph_rst_n,
    input  ready,
    input  lost_count,
    input  timeout_err
  );

endinterface

// File: rtl/pll_reset_seq_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level into clk.
// Latency: 2 clk edges from a sampled input change to q.
// Backpressure: none.
//   clk, rst_n : destination clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : synchronized output
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Staged reset release behind a PLL lock, with loss counting and lock timeout.
// Latency: sys_rst_n rises LOCK_CYCLES+1 edges after lock is first sampled,
//          periph_rst_n STAGE_GAP edges later; loss asserts resets 2 edges after sampling.
// Backpressure: none; outputs are registered levels.
//   clk, rst_n : PLL output clock, async active-low reset
//   bus        : locked/lost_clr in; sys_rst_n, periph_rst_n, ready,
//                lost_count, timeout_err out
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic            clk,
  input  logic            rst_n,
  pll_reset_seq_if.slave  bus
);

  localparam int CW = cnt_width(LOCK_CYCLES, STAGE_GAP, TIMEOUT_CYCLES);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [LOST_W-1:0] LOST_MAX = '1;
  localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

  logic locked_s;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              periph_rst_n_q, periph_rst_n_d;
  logic              ready_q, ready_d;
  logic [LOST_W-1:0] lost_count_q, lost_count_d;
  logic              timeout_err_q, timeout_err_d;

  logic loss;
  logic acquiring;

  // The only consumer of the raw lock input.
  bit_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.locked),
    .q     (locked_s)
  );

  // Only a drop after release is a counted loss event.
  assign loss      = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !locked_s;
  assign acquiring = (state_q == ST_WAIT) || (state_q == ST_STABLE);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sys_rst_n_d    = sys_rst_n_q;
    periph_rst_n_d = periph_rst_n_q;

    case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        if (locked_s) begin
          // This cycle is already the first good lock cycle, so count it.
          state_d = ST_STABLE;
          cnt_d   = CNT_ONE;
        end
      end

      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d     = ST_RELEASE;
          cnt_d       = '0;
          sys_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (!locked_s) begin
          state_d        = ST_WAIT;
          cnt_d          = '0;
          sys_rst_n_d    = 1'b0;
          periph_rst_n_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          state_d        = ST_RUN;
          cnt_d          = '0;
          periph_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_d        = ST_WAIT;
          cnt_d          = '0;
          sys_rst_n_d    = 1'b0;
          periph_rst_n_d = 1'b0;
        end
      end

      default: begin
        state_d        = ST_WAIT;
        cnt_d          = '0;
        sys_rst_n_d    = 1'b0;
        periph_rst_n_d = 1'b0;
      end
    endcase

    ready_d = periph_rst_n_d;

    // A clear always wins, but a loss in the same cycle is still recorded.
    lost_count_d = lost_count_q;
    if (bus.lost_clr) begin
      lost_count_d = loss ? LOST_ONE : '0;
    end else if (loss && (lost_count_q != LOST_MAX)) begin
      lost_count_d = lost_count_q + LOST_ONE;
    end

    // Timeout counter parks at its limit once the sticky flag is set.
    tcnt_d        = tcnt_q;
    timeout_err_d = timeout_err_q;
    if (acquiring) begin
      if (tcnt_q == TO_LAST) begin
        timeout_err_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + CNT_ONE;
      end
    end
    if (!acquiring || (state_d == ST_RELEASE)) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_WAIT;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      sys_rst_n_q    <= 1'b0;
      periph_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lost_count_q   <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tcnt_q         <= tcnt_d;
      sys_rst_n_q    <= sys_rst_n_d;
      periph_rst_n_q <= periph_rst_n_d;
      ready_q        <= ready_d;
      lost_count_q   <= lost_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.sys_rst_n    = sys_rst_n_q;
  assign bus.periph_rst_n = periph_rst_n_q;
  assign bus.ready        = ready_q;
  assign bus.lost_count   = lost_count_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_CYCLES=8, STAGE_GAP=4, TIMEOUT_CYCLES=32.
// Edge numbering: locked is changed 1 ns after a rising edge; the next rising edge is E0.
// Outputs are sampled 1 ns after rising edges.
module tb_pll_reset_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pll_reset_seq_if bus ();

  pll_reset_seq #(
    .LOCK_CYCLES    (8),
    .STAGE_GAP      (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset for three edges and releases it 1 ns after a rising edge.
  task automatic apply_reset();
    bus.locked   = 1'b0;
    bus.lost_clr = 1'b0;
    rst_n        = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.locked   = 1'b0;
    bus.lost_clr = 1'b0;
    rst_n        = 1'b0;
    step(2);
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys got %b want 0", bus.sys_rst_n); end
    checks++; if (bus.periph_rst_n !== 1'b0) begin errors++; $display("FAIL reset_periph got %b want 0", bus.periph_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    checks++; if (bus.lost_count !== 8'd0) begin errors++; $display("FAIL reset_lost got %0d want 0", bus.lost_count); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.timeout_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    apply_reset();
    bus.locked = 1'b1;
    step(9);  // after E8
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL clean_sys_E8 got %b want 0", bus.sys_rst_n); end
    step(1);  // after E9
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL clean_sys_E9 got %b want 1", bus.sys_rst_n); end
    checks++; if (bus.periph_rst_n !== 1'b0) begin errors++; $display("FAIL clean_periph_E9 got %b want 0", bus.periph_rst_n); end
    step(3);  // after E12
    checks++; if (bus.periph_rst_n !== 1'b0) begin errors++; $display("FAIL clean_periph_E12 got %b want 0", bus.periph_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL clean_ready_E12 got %b want 0", bus.ready); end
    step(1);  // after E13
    checks++; if (bus.periph_rst_n !== 1'b1) begin errors++; $display("FAIL clean_periph_E13 got %b want 1", bus.periph_rst_n); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL clean_ready_E13 got %b want 1", bus.ready); end
    checks++; if (bus.lost_count !== 8'd0) begin errors++; $display("FAIL clean_lost got %0d want 0", bus.lost_count); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL clean_timeout got %b want 0", bus.timeout_err); end
  endtask

  // Glitch sampled at E5; effective fresh start is E6, so release after E15.
  task automatic test_glitch();
    apply_reset();
    bus.locked = 1'b1;
    step(5);  // after E4
    bus.locked = 1'b0;
    step(1);  // after E5
    bus.locked = 1'b1;
    step(4);  // after E9
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL glitch_sys_E9 got %b want 0", bus.sys_rst_n); end
    step(5);  // after E14
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL glitch_sys_E14 got %b want 0", bus.sys_rst_n); end
    step(1);  // after E15
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL glitch_sys_E15 got %b want 1", bus.sys_rst_n); end
    step(4);  // after E19
    checks++; if (bus.periph_rst_n !== 1'b1) begin errors++; $display("FAIL glitch_periph_E19 got %b want 1", bus.periph_rst_n); end
    checks++; if (bus.lost_count !== 8'd0) begin errors++; $display("FAIL glitch_lost got %0d want 0", bus.lost_count); end
  endtask

  task automatic test_loss_run();
    apply_reset();
    bus.locked = 1'b1;
    step(16);  // well into RUN
    bus.locked = 1'b0;
    step(2);   // after L1
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_sys_L1 got %b want 1", bus.sys_rst_n); end
    step(1);   // after L2
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL loss_sys_L2 got %b want 0", bus.sys_rst_n); end
    checks++; if (bus.periph_rst_n !== 1'b0) begin errors++; $display("FAIL loss_periph_L2 got %b want 0", bus.periph_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL loss_ready_L2 got %b want 0", bus.ready); end
    checks++; if (bus.lost_count !== 8'd1) begin errors++; $display("FAIL loss_count got %0d want 1", bus.lost_count); end
    bus.locked = 1'b1;
    step(9);   // after E8
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL relock_sys_E8 got %b want 0", bus.sys_rst_n); end
    step(1);   // after E9
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL relock_sys_E9 got %b want 1", bus.sys_rst_n); end
    step(3);   // after E12
    checks++; if (bus.periph_rst_n !== 1'b0) begin errors++; $display("FAIL relock_periph_E12 got %b want 0", bus.periph_rst_n); end
    step(1);   // after E13
    checks++; if (bus.periph_rst_n !== 1'b1) begin errors++; $display("FAIL relock_periph_E13 got %b want 1", bus.periph_rst_n); end
    checks++; if (bus.lost_count !== 8'd1) begin errors++; $display("FAIL relock_lost got %0d want 1", bus.lost_count); end
  endtask

  // Each round: lock up into RELEASE, drop lock, wait until the loss lands (L2).
  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      bus.locked = 1'b1;
      step(11);
      bus.locked = 1'b0;
      step(3);
      if (i == 0) begin
        checks++; if (bus.lost_count !== 8'd1) begin errors++; $display("FAIL sat_first got %0d want 1", bus.lost_count); end
      end
      if (i == 254) begin
        checks++; if (bus.lost_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", bus.lost_count); end
      end
    end
    checks++; if (bus.lost_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", bus.lost_count); end

    // Clear coincident with a loss while saturated
    bus.locked = 1'b1;
    step(11);
    bus.locked = 1'b0;
    step(2);   // after L1
    bus.lost_clr = 1'b1;
    step(1);   // after L2
    bus.lost_clr = 1'b0;
    checks++; if (bus.lost_count !== 8'd1) begin errors++; $display("FAIL clr_with_loss got %0d want 1", bus.lost_count); end

    bus.locked = 1'b1;
    step(11);
    bus.locked = 1'b0;
    step(3);
    checks++; if (bus.lost_count !== 8'd2) begin errors++; $display("FAIL count_after_clr got %0d want 2", bus.lost_count); end

    bus.lost_clr = 1'b1;
    step(1);
    bus.lost_clr = 1'b0;
    checks++; if (bus.lost_count !== 8'd0) begin errors++; $display("FAIL clr_alone got %0d want 0", bus.lost_count); end
  endtask

  task automatic test_timeout();
    apply_reset();
    step(31);
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_31 got %b want 0", bus.timeout_err); end
    step(1);
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_32 got %b want 1", bus.timeout_err); end
    bus.locked = 1'b1;
    step(14);  // after E13
    checks++; if (bus.periph_rst_n !== 1'b1) begin errors++; $display("FAIL timeout_lock_periph got %b want 1", bus.periph_rst_n); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", bus.timeout_err); end
    apply_reset();
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_cleared got %b want 0", bus.timeout_err); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.locked = 1'b1;
    step(11);  // after E10: RELEASE
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL async_pre_sys got %b want 1", bus.sys_rst_n); end
    #2;
    rst_n = 1'b0;
    #1;        // mid-cycle, no edge yet
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_sys got %b want 0", bus.sys_rst_n); end
    checks++; if (bus.periph_rst_n !== 1'b0) begin errors++; $display("FAIL async_periph got %b want 0", bus.periph_rst_n); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b want 0", bus.ready); end
    checks++; if (bus.lost_count !== 8'd0) begin errors++; $display("FAIL async_lost got %0d want 0", bus.lost_count); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL async_timeout got %b want 0", bus.timeout_err); end
    step(5);   // lock still high, reset held
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_held_sys got %b want 0", bus.sys_rst_n); end
    rst_n = 1'b1;
    step(9);   // after E8 from release of rst_n: full sequence restarts
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_restart_E8 got %b want 0", bus.sys_rst_n); end
    step(1);
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL async_restart_E9 got %b want 1", bus.sys_rst_n); end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.locked   = 1'b0;
    bus.lost_clr = 1'b0;
    test_reset();
    test_clean_lock();
    test_glitch();
    test_loss_run();
    test_saturation();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer that sits directly downstream of the ECP5 system PLL. It consumes the PLL's asynchronous `locked` output and produces staged, glitch-free reset releases for the logic clocked by the PLL output clock. Before releasing reset it requires lock to be stable for a programmable interval. It re-asserts reset on loss of lock, counts lock-loss events, and flags a lock timeout.

## Interface
Parameters:
- `LOCK_CYCLES`, 1024: consecutive synchronized-lock cycles required before `sys_rst_n` releases (≥2).
- `STAGE_GAP`, 16: cycles between `sys_rst_n` release and `periph_rst_n` release (≥1).
- `TIMEOUT_CYCLES`, 65536: cycles after reset or loss without reaching release before `timeout_err` sets.

Ports:
- `clk` in 1: PLL output clock (e.g. 125 MHz).
- `rst_n` in 1: **asynchronous, active-low** reset. Single clock domain.
- `locked` in 1: PLL lock, asynchronous to `clk`.
- `lost_clr` in 1: synchronous one-cycle pulse that clears `lost_count`.
- `sys_rst_n` out 1: core reset, active-low, released first.
- `periph_rst_n` out 1: peripheral reset, active-low, released `STAGE_GAP` cycles later.
- `ready` out 1: high exactly when `periph_rst_n` is high.
- `lost_count` out 8: number of lock losses after release, saturating at 255.
- `timeout_err` out 1: sticky flag; lock was not achieved in time.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. No other logic samples raw `locked`.
- FSM states:
  - WAIT: counter is 0. Moves to STABLE when `locked_s` = 1.
  - STABLE: counter increments each cycle. If `locked_s` = 0, returns to WAIT and clears the counter. When the counter reaches `LOCK_CYCLES`-1 with `locked_s` = 1, moves to RELEASE, clears the counter and sets `sys_rst_n` = 1.
  - RELEASE: counter increments. When it reaches `STAGE_GAP`-1, moves to RUN and sets `periph_rst_n` = `ready` = 1.
  - RUN: holds.
- Loss of lock in RELEASE or RUN (`locked_s` = 0):
  - Next state is WAIT.
  - `sys_rst_n`, `periph_rst_n` and `ready` go to 0 at the same edge.
  - `lost_count` increments, saturating at 255.
- Loss of lock in WAIT or STABLE does not count.
- `lost_clr` and a counted loss in the same cycle: `lost_count` becomes 1. At 255, `lost_clr` wins and gives 0, or 1 if a loss coincides.
- Timeout counter:
  - Runs while the FSM is in WAIT or STABLE; clears on entering RELEASE.
  - Sets `timeout_err` when it reaches `TIMEOUT_CYCLES`-1.
  - `timeout_err` stays set until `rst_n`. A later successful lock does not clear it.
- Counter width is $clog2 of the maximum of (`LOCK_CYCLES`, `STAGE_GAP`, `TIMEOUT_CYCLES`) + 1. The timeout counter is separate from the FSM counter.
- Reset values (`rst_n` = 0, asynchronous):
  - FSM in WAIT, all counters 0, both synchronizer flops 0.
  - `sys_rst_n` = 0, `periph_rst_n` = 0, `ready` = 0, `lost_count` = 0, `timeout_err` = 0.
- `rst_n` asserted mid-sequence forces the reset state immediately. There is no partial release.
- All outputs are registered; none is combinational from inputs.

## Timing
- Let edge E0 be the first edge where `locked` is sampled at 1.
  - `locked_s` = 1 after E1.
  - `sys_rst_n` = 1 after edge E(1+`LOCK_CYCLES`).
  - `periph_rst_n` = 1 after E(1+`LOCK_CYCLES`+`STAGE_GAP`).
- Loss: `locked` sampled at 0 at edge L0 → `locked_s` = 0 after L1 → all resets low after L2. Worst-case assertion latency is 2 cycles plus setup.
- A `locked` glitch of one or more cycles during STABLE restarts the full `LOCK_CYCLES` count.
- `rst_n` assertion takes effect asynchronously. Deassertion is the system's responsibility to synchronize to `clk`.

## Structure
- `pll_reset_pkg` holds:
  - the FSM state enum (WAIT, STABLE, RELEASE, RUN);
  - `LOST_W` = 8;
  - a `cnt_width` function.
- Sub-module `bit_sync` is a 2-flop synchronizer with async active-low reset to 0. It is reused for `locked`.

## Test plan
Run with `LOCK_CYCLES`=8, `STAGE_GAP`=4, `TIMEOUT_CYCLES`=32.
- Clean lock: `locked` goes high and stays high from E0 → `sys_rst_n` rises after E9, `periph_rst_n` and `ready` rise after E13, `lost_count` = 0.
- Glitch during STABLE: `locked` low for 1 cycle at E5 → no release until 8 fresh `locked_s` cycles have passed, `lost_count` stays 0.
- Loss in RUN: drop `locked` at L0 → all resets low after L2, `lost_count` = 1. Relock → release again with the same 9/13 latency.
- Saturation and clear:
  - 256 losses → `lost_count` = 255.
  - `lost_clr` → 0.
  - `lost_clr` coincident with a loss → 1.
- Timeout: `locked` held low for 32 cycles → `timeout_err` = 1 after the 32nd edge. It stays 1 after a later successful lock and clears only on `rst_n`.
- Async reset mid-RELEASE: `rst_n` low → `sys_rst_n` = 0 with no clock edge needed, and every output at its reset value.
